// File: rtl/pipe_pkg.sv
// pipe_pkg: stage/register indices and controller state type for pipe_ctrl
package pipe_pkg;
  localparam int IF_STG  = 0;
  localparam int ID_STG  = 1;
  localparam int EX_STG  = 2;
  localparam int MEM_STG = 3;
  localparam int REG_PC     = 0;
  localparam int REG_IF_ID  = 1;
  localparam int REG_ID_EX  = 2;
  localparam int REG_EX_MEM = 3;
  localparam int REG_MEM_WB = 4;
  localparam logic [4:0] REDIR_BUBBLE = (5'd1 << REG_IF_ID) | (5'd1 << REG_ID_EX);
  typedef enum logic {RUN, PEND} state_e;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-low clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q;
  // count up on inc, holding at all-ones
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else if (inc_i && !(&count_q)) count_q <= count_q + 1'b1;
  assign count_o = count_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/bubble/redirect control; PIPE_PERF_EN adds perf counters
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int PERF_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_req,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  input  logic              mem_stall_req,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  output logic [4:0]        stall,
  output logic [4:0]        bubble,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);
  state_e            state_q;
  logic [ADDR_W-1:0] pend_target_q;
  logic [3:0]        req;
  logic [4:0]        n_stall, n_bubble;
  logic              busy, go;
  assign req = {mem_stall_req, ex_stall_req, id_stall_req, if_stall_req};
  assign busy = ex_stall_req | mem_stall_req;
  assign go = rst && !busy && (state_q == PEND || ex_redirect);
  // thermometer stall up to the highest requesting stage; bubble sits just past its top
  always_comb begin
    n_stall[REG_PC]     = |req[MEM_STG:IF_STG];
    n_stall[REG_IF_ID]  = |req[MEM_STG:ID_STG];
    n_stall[REG_ID_EX]  = |req[MEM_STG:EX_STG];
    n_stall[REG_EX_MEM] = req[MEM_STG];
    n_stall[REG_MEM_WB] = 1'b0;
    n_bubble = {n_stall[3:0], 1'b0} & ~n_stall;
    stall = (!rst || go) ? 5'd0 : n_stall;
    bubble = !rst ? 5'h1f : go ? REDIR_BUBBLE : n_bubble;
    pc_redirect = go;
    pc_target = !go ? '0 : (state_q == PEND) ? pend_target_q : ex_target;
  end
  // a redirect that arrives while EX/MEM is held waits in PEND until the hold clears
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= RUN;
      pend_target_q <= '0;
    end else if (go) state_q <= RUN;
    else if (state_q == RUN && ex_redirect && busy) begin
      state_q <= PEND;
      pend_target_q <= ex_target;
    end
`ifdef PIPE_PERF_EN
  sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc_i(stall[REG_PC]), .count_o(stall_cycles));
  sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc_i(pc_redirect), .count_o(flush_count));
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule
